ram_req_responder: RTL and testbench

- On-chip memory responder for the ram request/ready/valid interface the MMU drives for data accesses.
- Accepts single read or write requests, serialises them through a small FSM, and returns read data with a one-cycle valid pulse.
- Backed by an inferred synchronous word array. Used as a DDR3-free substitute behind the MMU in simulation and small FPGA builds.

---
 rtl/ram_req_responder_if.sv | 51 +++++
 rtl/ram_req_responder.sv | 194 +++++++++++++++++++
 tb/tb_ram_req_responder.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_req_responder_if.sv
// ram_req_responder_if
//   Request/ready/valid bus between the MMU data port and the on-chip RAM
//   responder.
//   master : requester side (drives addresses, data and request levels)
//   slave  : responder side (drives read data, valid pulse and readies)
//   Signals:
//     addr_in         byte address of request
//     write_data_in   write data, byte mode uses [7:0]
//     read_req        read request level
//     write_req       write request level
//     bit32_select    1 = word access, 0 = byte access on lane addr_in[1:0]
//     read_data_out   read data, byte mode zero-extended
//     read_data_valid one-cycle pulse with read_data_out
//     read_ready      responder can accept a read
//     write_ready     responder can accept a write
`timescale 1ns/1ps
interface ram_req_responder_if;
    logic [31:0] addr_in;
    logic [31:0] write_data_in;
    logic        read_req;
    logic        write_req;
    logic        bit32_select;
    logic [31:0] read_data_out;
    logic        read_data_valid;
    logic        read_ready;
    logic        write_ready;

    modport master (
        output addr_in,
        output write_data_in,
        output read_req,
        output write_req,
        output bit32_select,
        input  read_data_out,
        input  read_data_valid,
        input  read_ready,
        input  write_ready
    );

    modport slave (
        input  addr_in,
        input  write_data_in,
        input  read_req,
        input  write_req,
        input  bit32_select,
        output read_data_out,
        output read_data_valid,
        output read_ready,
        output write_ready
    );
endinterface

// File: rtl/ram_req_responder.sv
// ram_req_responder
//   On-chip RAM standing in for DDR behind the MMU data port. Single read or
//   write requests are serialised through a small FSM; reads return data with
//   a one-cycle valid pulse READ_LATENCY cycles after acceptance.
//   Ports:
//     CLK   clock, all logic on rising edge
//     RSTn  synchronous active-low reset (memory contents are kept)
//     en    global enable; 0 freezes FSM, counter and memory
//     bus   ram_req_responder_if.slave request/response bus
//     err   (RAM_REQ_ERR_EN only) out-of-range access pulse
//   Optional feature macro: RAM_REQ_ERR_EN
//     Defined   -> addresses with addr_in[31:ADDR_WIDTH] != 0 are rejected:
//                  writes are dropped, reads return 32'hDEADBEEF, err pulses.
//     Undefined -> upper address bits are ignored and addresses alias.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | ready for a request; write has priority over read
//   READ_WAIT  | read issued to array, counting down the read latency
//   READ_RESP  | read_data_out valid, read_data_valid high for one cycle
//   WRITE_BUSY | write done, counting down the write busy time
`timescale 1ns/1ps
module ram_req_responder #(
    parameter int ADDR_WIDTH    = 16,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                en,
`ifdef RAM_REQ_ERR_EN
    output logic                err,
`endif
    ram_req_responder_if.slave  bus
);

    localparam int         DEPTH       = 2 ** (ADDR_WIDTH - 2);
    localparam logic [2:0] RD_CNT_INIT = 3'(READ_LATENCY - 1);
    localparam logic [2:0] WR_CNT_INIT = 3'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        READ_RESP  = 2'd2,
        WRITE_BUSY = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [2:0]              r_cnt;
    logic [2:0]              w_cnt_nxt;
    logic                    r_ready;
    logic [31:0]             r_rdata;
    logic [31:0]             r_word;
    logic [1:0]              r_lane;
    logic                    r_bit32;
    logic                    w_wr_acc;
    logic                    w_rd_acc;
    logic                    w_rdata_load;
    logic                    w_mem_we;
    logic                    w_oor;
    logic [31:0]             w_rdata_fmt;
    logic [ADDR_WIDTH-3:0]   w_idx;

    logic [31:0] r_mem [DEPTH];

    assign w_idx = bus.addr_in[ADDR_WIDTH-1:2];

`ifdef RAM_REQ_ERR_EN
    logic r_werr;
    logic r_roor;

    assign w_oor    = |bus.addr_in[31:ADDR_WIDTH];
    assign w_mem_we = w_wr_acc & ~w_oor;
`else
    logic w_unused_addr;

    assign w_oor         = 1'b0;
    assign w_mem_we      = w_wr_acc;
    assign w_unused_addr = ^{bus.addr_in[31:ADDR_WIDTH], w_oor};
`endif

    // Next state / counter. Nothing advances while disabled or in reset, so a
    // request seen on the same edge as reset never reaches the array.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_wr_acc     = 1'b0;
        w_rd_acc     = 1'b0;
        w_rdata_load = 1'b0;
        if (en && RSTn) begin
            case (r_state)
                IDLE: begin
                    if (bus.write_req && r_ready) begin
                        w_wr_acc    = 1'b1;
                        w_state_nxt = WRITE_BUSY;
                        w_cnt_nxt   = WR_CNT_INIT;
                    end else if (bus.read_req && r_ready) begin
                        w_rd_acc    = 1'b1;
                        w_state_nxt = READ_WAIT;
                        w_cnt_nxt   = RD_CNT_INIT;
                    end
                end
                READ_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        w_state_nxt  = READ_RESP;
                        w_rdata_load = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end
                end
                READ_RESP: begin
                    w_state_nxt = IDLE;
                end
                WRITE_BUSY: begin
                    if (r_cnt == 3'd0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_rdata_fmt = r_bit32 ? r_word : {24'h0, r_word[{r_lane, 3'b000} +: 8]};
`ifdef RAM_REQ_ERR_EN
        if (r_roor) begin
            w_rdata_fmt = 32'hDEADBEEF;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
            r_ready <= 1'b0;
            r_rdata <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= en && (w_state_nxt == IDLE);
            if (w_rdata_load) begin
                r_rdata <= w_rdata_fmt;
            end
        end
    end

    // Array and read-side capture; no reset so the RAM infers cleanly.
    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            if (bus.bit32_select) begin
                r_mem[w_idx] <= bus.write_data_in;
            end else begin
                r_mem[w_idx][{bus.addr_in[1:0], 3'b000} +: 8] <= bus.write_data_in[7:0];
            end
        end
        if (w_rd_acc) begin
            r_word  <= r_mem[w_idx];
            r_lane  <= bus.addr_in[1:0];
            r_bit32 <= bus.bit32_select;
        end
    end

`ifdef RAM_REQ_ERR_EN
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_werr <= 1'b0;
            r_roor <= 1'b0;
        end else begin
            if (en) begin
                r_werr <= w_wr_acc & w_oor;
            end
            if (w_rd_acc) begin
                r_roor <= w_oor;
            end
        end
    end

    assign err = r_werr | (bus.read_data_valid & r_roor);
`endif

    // Readies are registered but also masked by en so a disable is seen at once.
    assign bus.read_ready      = r_ready & en;
    assign bus.write_ready     = r_ready & en;
    assign bus.read_data_valid = (r_state == READ_RESP) & en;
    assign bus.read_data_out   = r_rdata;

endmodule

// File: tb/tb_ram_req_responder.sv
`timescale 1ns/1ps
module tb_ram_req_responder;

    localparam int ADDR_WIDTH    = 16;
    localparam int READ_LATENCY  = 2;
    localparam int WRITE_LATENCY = 1;

    logic CLK;
    logic RSTn;
    logic en;
`ifdef RAM_REQ_ERR_EN
    logic err;
    logic last_err;
`endif

    int n_checks;
    int n_fail;
    int valid_seen;
    logic [31:0] exp_q[$];

    ram_req_responder_if bus();

    ram_req_responder #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .READ_LATENCY  (READ_LATENCY),
        .WRITE_LATENCY (WRITE_LATENCY)
    ) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .en   (en),
`ifdef RAM_REQ_ERR_EN
        .err  (err),
`endif
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (bus.read_data_valid === 1'b1) valid_seen++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish, expected finish before 200000ns");
        $fatal(1, "timeout");
    end

    task automatic wait_ready(input bit is_write, input string nm);
        int n;
        n = 0;
        @(negedge CLK);
        while (((is_write ? bus.write_ready : bus.read_ready) !== 1'b1) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        n_checks++;
        if ((is_write ? bus.write_ready : bus.read_ready) !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready_timeout ready=%b expected 1", nm,
                     is_write ? bus.write_ready : bus.read_ready);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic b32, input string nm);
        wait_ready(1'b1, nm);
        bus.addr_in       = a;
        bus.write_data_in = d;
        bus.bit32_select  = b32;
        bus.write_req     = 1'b1;
        @(posedge CLK);
        #1;
        bus.write_req     = 1'b0;
    endtask

    task automatic rd_check(input logic [31:0] a, input logic b32, input logic [31:0] exp, input string nm);
        int edges;
        logic [31:0] e;
        wait_ready(1'b0, nm);
        bus.addr_in      = a;
        bus.bit32_select = b32;
        bus.read_req     = 1'b1;
        exp_q.push_back(exp);
        @(posedge CLK);
        #1;
        bus.read_req = 1'b0;
        edges = 0;
        while (bus.read_data_valid !== 1'b1 && edges < 20) begin
            @(posedge CLK);
            #1;
            edges++;
        end
`ifdef RAM_REQ_ERR_EN
        last_err = err;
`endif
        e = exp_q.pop_front();
        n_checks++;
        if (edges != READ_LATENCY) begin
            n_fail++;
            $display("FAIL %s_latency got %0d cycles expected %0d", nm, edges, READ_LATENCY);
        end
        n_checks++;
        if (bus.read_data_out !== e) begin
            n_fail++;
            $display("FAIL %s_data got %h expected %h", nm, bus.read_data_out, e);
        end
        @(posedge CLK);
        #1;
        n_checks++;
        if (bus.read_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_pulse_width valid=%b expected 0", nm, bus.read_data_valid);
        end
        n_checks++;
        if (bus.read_data_out !== e) begin
            n_fail++;
            $display("FAIL %s_hold got %h expected %h", nm, bus.read_data_out, e);
        end
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        en   = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if (bus.read_ready !== 1'b0 || bus.write_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready got rd=%b wr=%b expected 0 0", bus.read_ready, bus.write_ready);
        end
        n_checks++;
        if (bus.read_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got %b expected 0", bus.read_data_valid);
        end
        n_checks++;
        if (bus.read_data_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata got %h expected 00000000", bus.read_data_out);
        end
        RSTn = 1'b1;
        @(posedge CLK);
        #1;
        n_checks++;
        if (bus.read_ready !== 1'b1 || bus.write_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_ready got rd=%b wr=%b expected 1 1", bus.read_ready, bus.write_ready);
        end
        n_checks++;
        if (bus.read_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release_valid got %b expected 0", bus.read_data_valid);
        end
    endtask

    task automatic test_word_rw();
        wr(32'h0000_0010, 32'h1234_5678, 1'b1, "word_wr");
        for (int i = 0; i < WRITE_LATENCY; i++) begin
            n_checks++;
            if (bus.write_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL wr_busy_%0d write_ready=%b expected 0", i, bus.write_ready);
            end
            @(posedge CLK);
            #1;
        end
        n_checks++;
        if (bus.write_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_ready_return write_ready=%b expected 1", bus.write_ready);
        end
        rd_check(32'h0000_0010, 1'b1, 32'h1234_5678, "word_rd");
    endtask

    task automatic test_byte();
        wr(32'h0000_0011, 32'hFFFF_FFAB, 1'b0, "byte_wr");
        rd_check(32'h0000_0010, 1'b1, 32'h1234_AB78, "byte_merge_rd");
        rd_check(32'h0000_0013, 1'b0, 32'h0000_0012, "byte_rd_lane3");
        rd_check(32'h0000_0011, 1'b0, 32'h0000_00AB, "byte_rd_lane1");
    endtask

    task automatic test_simultaneous();
        int v0;
        wait_ready(1'b1, "simul");
        bus.addr_in       = 32'h0000_0020;
        bus.write_data_in = 32'hCAFE_F00D;
        bus.bit32_select  = 1'b1;
        bus.write_req     = 1'b1;
        bus.read_req      = 1'b1;
        v0 = valid_seen;
        @(posedge CLK);
        #1;
        bus.write_req = 1'b0;
        bus.read_req  = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
        n_checks++;
        if (valid_seen != v0) begin
            n_fail++;
            $display("FAIL simul_no_valid got %0d pulses expected 0", valid_seen - v0);
        end
        rd_check(32'h0000_0020, 1'b1, 32'hCAFE_F00D, "simul_rd");
    endtask

    task automatic test_reset_abort();
        int v0;
        wait_ready(1'b0, "abort");
        bus.addr_in      = 32'h0000_0010;
        bus.bit32_select = 1'b1;
        bus.read_req     = 1'b1;
        v0 = valid_seen;
        @(posedge CLK);
        #1;
        bus.read_req = 1'b0;
        RSTn = 1'b0;
        @(posedge CLK);
        #1;
        n_checks++;
        if (bus.read_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_ready_in_reset got %b expected 0", bus.read_ready);
        end
        RSTn = 1'b1;
        @(posedge CLK);
        #1;
        n_checks++;
        if (bus.read_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_ready_return got %b expected 1", bus.read_ready);
        end
        repeat (8) @(posedge CLK);
        #1;
        n_checks++;
        if (valid_seen != v0) begin
            n_fail++;
            $display("FAIL abort_no_valid got %0d pulses expected 0", valid_seen - v0);
        end
        n_checks++;
        if (bus.read_data_out !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_rdata_cleared got %h expected 00000000", bus.read_data_out);
        end
    endtask

    task automatic test_en_freeze();
        int edges;
        logic [31:0] e;
        wait_ready(1'b0, "freeze");
        bus.addr_in      = 32'h0000_0020;
        bus.bit32_select = 1'b1;
        bus.read_req     = 1'b1;
        exp_q.push_back(32'hCAFE_F00D);
        @(posedge CLK);
        #1;
        bus.read_req = 1'b0;
        en = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if (bus.read_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL freeze_valid got %b expected 0", bus.read_data_valid);
        end
        en = 1'b1;
        edges = 3;
        while (bus.read_data_valid !== 1'b1 && edges < 30) begin
            @(posedge CLK);
            #1;
            edges++;
        end
        e = exp_q.pop_front();
        n_checks++;
        if (edges != READ_LATENCY + 3) begin
            n_fail++;
            $display("FAIL freeze_latency got %0d cycles expected %0d", edges, READ_LATENCY + 3);
        end
        n_checks++;
        if (bus.read_data_out !== e) begin
            n_fail++;
            $display("FAIL freeze_data got %h expected %h", bus.read_data_out, e);
        end
        repeat (2) @(posedge CLK);
        #1;
        en = 1'b0;
        #1;
        n_checks++;
        if (bus.read_ready !== 1'b0 || bus.write_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL en_low_ready got rd=%b wr=%b expected 0 0", bus.read_ready, bus.write_ready);
        end
        en = 1'b1;
    endtask

    task automatic test_out_of_range();
        wr(32'h0000_0004, 32'h1111_2222, 1'b1, "oor_pre_wr");
        wr(32'h0001_0004, 32'h5555_AAAA, 1'b1, "oor_wr");
`ifdef RAM_REQ_ERR_EN
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_wr_err got %b expected 1", err);
        end
        @(posedge CLK);
        #1;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_wr_err_pulse got %b expected 0", err);
        end
        rd_check(32'h0000_0004, 1'b1, 32'h1111_2222, "oor_alias_untouched");
        n_checks++;
        if (last_err !== 1'b0) begin
            n_fail++;
            $display("FAIL inrange_rd_err got %b expected 0", last_err);
        end
        rd_check(32'h0001_0004, 1'b1, 32'hDEAD_BEEF, "oor_rd");
        n_checks++;
        if (last_err !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_rd_err got %b expected 1", last_err);
        end
`else
        rd_check(32'h0000_0004, 1'b1, 32'h5555_AAAA, "alias_rd");
`endif
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        valid_seen        = 0;
        RSTn              = 1'b0;
        en                = 1'b1;
        bus.addr_in       = 32'h0;
        bus.write_data_in = 32'h0;
        bus.read_req      = 1'b0;
        bus.write_req     = 1'b0;
        bus.bit32_select  = 1'b1;
`ifdef RAM_REQ_ERR_EN
        last_err          = 1'b0;
`endif
        test_reset();
        test_word_rw();
        test_byte();
        test_simultaneous();
        test_reset_abort();
        test_en_freeze();
        test_out_of_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
